// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync generator.
// A programmable divider produces the pixel strobe, and column and row counters
// follow it. hsync, vsync and visible are registered from the next-state position,
// so they change on the same clock edge as col/row.
// Timing is reprogrammable at runtime. A write lands in a pending copy, and that
// copy becomes active only on the new_frame cycle, so a mode switch never tears.
module vga_timing_gen #(
  parameter int c_clk_div      = 4,
  parameter int c_nb_div       = 4,
  parameter int c_nb_pxls      = 11,
  parameter int c_nb_lines     = 10,
  parameter int c_hsync_act    = 0,
  parameter int c_vsync_act    = 0,
  parameter int c_pxl_visible  = 640,
  parameter int c_pxl_fporch   = 16,
  parameter int c_pxl_synch    = 96,
  parameter int c_pxl_total    = 800,
  parameter int c_line_visible = 480,
  parameter int c_line_fporch  = 9,
  parameter int c_line_synch   = 2,
  parameter int c_line_total   = 520
) (
  input  logic                  rst,
  input  logic                  clk,
  input  logic                  cfg_wr,
  input  logic [c_nb_pxls-1:0]  cfg_h_visible,
  input  logic [c_nb_pxls-1:0]  cfg_h_fporch,
  input  logic [c_nb_pxls-1:0]  cfg_h_synch,
  input  logic [c_nb_pxls-1:0]  cfg_h_total,
  input  logic [c_nb_lines-1:0] cfg_v_visible,
  input  logic [c_nb_lines-1:0] cfg_v_fporch,
  input  logic [c_nb_lines-1:0] cfg_v_synch,
  input  logic [c_nb_lines-1:0] cfg_v_total,
  output logic                  cfg_pend,
  output logic                  new_pxl,
  output logic                  new_line,
  output logic                  new_frame,
  output logic [c_nb_pxls-1:0]  col,
  output logic [c_nb_lines-1:0] row,
  output logic                  visible,
  output logic                  hsync,
  output logic                  vsync
);

  typedef struct packed {
    logic [c_nb_pxls-1:0]  h_visible;
    logic [c_nb_pxls-1:0]  h_fporch;
    logic [c_nb_pxls-1:0]  h_synch;
    logic [c_nb_pxls-1:0]  h_total;
    logic [c_nb_lines-1:0] v_visible;
    logic [c_nb_lines-1:0] v_fporch;
    logic [c_nb_lines-1:0] v_synch;
    logic [c_nb_lines-1:0] v_total;
  } timing_t;

  localparam timing_t c_act_rst = '{
    h_visible: c_nb_pxls'(c_pxl_visible),
    h_fporch:  c_nb_pxls'(c_pxl_fporch),
    h_synch:   c_nb_pxls'(c_pxl_synch),
    h_total:   c_nb_pxls'(c_pxl_total),
    v_visible: c_nb_lines'(c_line_visible),
    v_fporch:  c_nb_lines'(c_line_fporch),
    v_synch:   c_nb_lines'(c_line_synch),
    v_total:   c_nb_lines'(c_line_total)
  };

  localparam logic [c_nb_div-1:0] c_div_last = c_nb_div'(c_clk_div - 1);
  localparam logic c_hs_on = 1'(c_hsync_act);
  localparam logic c_vs_on = 1'(c_vsync_act);

  // Sync window bounds carry two extra bits. The stop bound adds three
  // counter-width terms, and it must not wrap even with every field at its maximum.
  localparam int c_hw = c_nb_pxls + 2;
  localparam int c_vw = c_nb_lines + 2;

  logic [c_nb_div-1:0]   div_q, div_d;
  logic [c_nb_pxls-1:0]  col_q, col_d;
  logic [c_nb_lines-1:0] row_q, row_d;
  timing_t               act_q, act_d;
  timing_t               pend_q, pend_d;
  logic                  cfg_pend_q, cfg_pend_d;
  logic                  visible_q, visible_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;

  logic [c_nb_pxls-1:0]  h_last;
  logic [c_nb_lines-1:0] v_last;
  logic                  last_col;
  logic                  last_row;
  logic                  apply;
  logic [c_hw-1:0]       hs_start, hs_stop;
  logic [c_vw-1:0]       vs_start, vs_stop;

  // Divider, column and row counters. A total of 0 behaves as 1, which pins the counter at 0.
  always_comb begin
    new_pxl   = (div_q == c_div_last);
    div_d     = new_pxl ? '0 : div_q + 1'b1;
    h_last    = (act_q.h_total == '0) ? '0 : act_q.h_total - 1'b1;
    v_last    = (act_q.v_total == '0) ? '0 : act_q.v_total - 1'b1;
    last_col  = (col_q == h_last);
    last_row  = (row_q == v_last);
    new_line  = new_pxl & last_col;
    new_frame = new_line & last_row;
    col_d     = col_q;
    row_d     = row_q;
    if (new_pxl) col_d = last_col ? '0 : col_q + 1'b1;
    if (new_line) row_d = last_row ? '0 : row_q + 1'b1;
  end

  // Pending/active config. A write that lands on the apply cycle stays pending for the next frame.
  always_comb begin
    apply      = new_frame & cfg_pend_q;
    act_d      = apply ? pend_q : act_q;
    pend_d     = pend_q;
    cfg_pend_d = cfg_pend_q & ~apply;
    if (cfg_wr) begin
      pend_d = '{cfg_h_visible, cfg_h_fporch, cfg_h_synch, cfg_h_total,
                 cfg_v_visible, cfg_v_fporch, cfg_v_synch, cfg_v_total};
      cfg_pend_d = 1'b1;
    end
  end

  // Decode from the next position and the config that will govern it, so the registered outputs have zero skew.
  always_comb begin
    hs_start  = {2'b00, act_d.h_visible} + {2'b00, act_d.h_fporch};
    hs_stop   = hs_start + {2'b00, act_d.h_synch};
    vs_start  = {2'b00, act_d.v_visible} + {2'b00, act_d.v_fporch};
    vs_stop   = vs_start + {2'b00, act_d.v_synch};
    visible_d = (col_d < act_d.h_visible) && (row_d < act_d.v_visible);
    hsync_d   = (({2'b00, col_d} >= hs_start) && ({2'b00, col_d} < hs_stop)) ? c_hs_on : ~c_hs_on;
    vsync_d   = (({2'b00, row_d} >= vs_start) && ({2'b00, row_d} < vs_stop)) ? c_vs_on : ~c_vs_on;
  end

  // State registers. Reset discards any pending config and restores the parameter timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      act_q      <= c_act_rst;
      pend_q     <= '0;
      cfg_pend_q <= 1'b0;
      visible_q  <= 1'b0;
      hsync_q    <= ~c_hs_on;
      vsync_q    <= ~c_vs_on;
    end else begin
      div_q      <= div_d;
      col_q      <= col_d;
      row_q      <= row_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      cfg_pend_q <= cfg_pend_d;
      visible_q  <= visible_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
    end
  end

  assign col      = col_q;
  assign row      = row_q;
  assign cfg_pend = cfg_pend_q;
  assign visible  = visible_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. It runs two lanes:
//   lane 0: default parameters, divide by 4, active-low syncs.
//   lane 1: divide by 1, active-high syncs, small default frame.
// Each lane has a model that works from the pixel index since the frame start,
// computed as (clocks / divider). From that index it derives column and row with div/mod.
// The model pushes one expected snapshot per clock. A negedge monitor pops each
// snapshot and compares it with the DUT outputs.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] col;
    logic [9:0]  row;
    logic        visible;
    logic        hsync;
    logic        vsync;
    logic        cfg_pend;
    logic        new_pxl;
    logic        new_line;
    logic        new_frame;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   done = 1'b0;

  logic        cfg_wr [2];
  logic [10:0] c_hv [2];
  logic [10:0] c_hf [2];
  logic [10:0] c_hs [2];
  logic [10:0] c_ht [2];
  logic [9:0]  c_vv [2];
  logic [9:0]  c_vf [2];
  logic [9:0]  c_vs [2];
  logic [9:0]  c_vt [2];

  logic [10:0] o_col [2];
  logic [9:0]  o_row [2];
  logic        o_vis [2];
  logic        o_hs [2];
  logic        o_vs [2];
  logic        o_pend [2];
  logic        o_np [2];
  logic        o_nl [2];
  logic        o_nf [2];

  always #5 clk = ~clk;

  task automatic finish_run();
    if (!done) begin
      done = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int DIV = (g == 0) ? 4 : 1;
    localparam bit HON = (g == 1);
    localparam bit VON = (g == 1);
    localparam int HV0 = (g == 0) ? 640 : 20;
    localparam int HF0 = (g == 0) ? 16 : 4;
    localparam int HS0 = (g == 0) ? 96 : 6;
    localparam int HT0 = (g == 0) ? 800 : 36;
    localparam int VV0 = (g == 0) ? 480 : 10;
    localparam int VF0 = (g == 0) ? 9 : 2;
    localparam int VS0 = (g == 0) ? 2 : 1;
    localparam int VT0 = (g == 0) ? 520 : 15;

    vga_timing_gen #(
      .c_clk_div(DIV), .c_nb_div(4), .c_nb_pxls(11), .c_nb_lines(10),
      .c_hsync_act(HON ? 1 : 0), .c_vsync_act(VON ? 1 : 0),
      .c_pxl_visible(HV0), .c_pxl_fporch(HF0), .c_pxl_synch(HS0), .c_pxl_total(HT0),
      .c_line_visible(VV0), .c_line_fporch(VF0), .c_line_synch(VS0), .c_line_total(VT0)
    ) dut (
      .rst(rst), .clk(clk), .cfg_wr(cfg_wr[g]),
      .cfg_h_visible(c_hv[g]), .cfg_h_fporch(c_hf[g]), .cfg_h_synch(c_hs[g]), .cfg_h_total(c_ht[g]),
      .cfg_v_visible(c_vv[g]), .cfg_v_fporch(c_vf[g]), .cfg_v_synch(c_vs[g]), .cfg_v_total(c_vt[g]),
      .cfg_pend(o_pend[g]), .new_pxl(o_np[g]), .new_line(o_nl[g]), .new_frame(o_nf[g]),
      .col(o_col[g]), .row(o_row[g]), .visible(o_vis[g]), .hsync(o_hs[g]), .vsync(o_vs[g])
    );

    int m_e = 0;
    int m_fs = 0;
    bit m_pend = 1'b0;
    int a_hv = HV0, a_hf = HF0, a_hs = HS0, a_ht = HT0;
    int a_vv = VV0, a_vf = VF0, a_vs = VS0, a_vt = VT0;
    int p_hv = 0, p_hf = 0, p_hs = 0, p_ht = 0;
    int p_vv = 0, p_vf = 0, p_vs = 0, p_vt = 0;
    obs_t q[$];

    function automatic obs_t predict(bit in_rst);
      obs_t r;
      int   ht, vt, p, c, w;
      bit   np;
      ht = (a_ht == 0) ? 1 : a_ht;
      vt = (a_vt == 0) ? 1 : a_vt;
      p  = (m_e - m_fs) / DIV;
      c  = p % ht;
      w  = (p / ht) % vt;
      np = ((m_e % DIV) == DIV - 1);
      r.col       = 11'(c);
      r.row       = 10'(w);
      r.new_pxl   = np;
      r.new_line  = np && (c == ht - 1);
      r.new_frame = r.new_line && (w == vt - 1);
      r.cfg_pend  = m_pend;
      if (in_rst) begin
        r.visible = 1'b0;
        r.hsync   = !HON;
        r.vsync   = !VON;
      end else begin
        r.visible = (c < a_hv) && (w < a_vv);
        r.hsync   = (c >= a_hv + a_hf && c < a_hv + a_hf + a_hs) ? HON : !HON;
        r.vsync   = (w >= a_vv + a_vf && w < a_vv + a_vf + a_vs) ? VON : !VON;
      end
      return r;
    endfunction

    // Reference model: one clock edge = one step of the frame-relative clock count.
    always @(posedge clk or posedge rst) begin
      int flen;
      if (rst) begin
        m_e = 0; m_fs = 0; m_pend = 1'b0;
        a_hv = HV0; a_hf = HF0; a_hs = HS0; a_ht = HT0;
        a_vv = VV0; a_vf = VF0; a_vs = VS0; a_vt = VT0;
        q.delete();
      end else begin
        flen = ((a_ht == 0) ? 1 : a_ht) * ((a_vt == 0) ? 1 : a_vt) * DIV;
        m_e++;
        if (m_e - m_fs >= flen) begin
          m_fs += flen;
          if (m_pend) begin
            a_hv = p_hv; a_hf = p_hf; a_hs = p_hs; a_ht = p_ht;
            a_vv = p_vv; a_vf = p_vf; a_vs = p_vs; a_vt = p_vt;
            m_pend = 1'b0;
          end
        end
        if (cfg_wr[g]) begin
          p_hv = int'(c_hv[g]); p_hf = int'(c_hf[g]); p_hs = int'(c_hs[g]); p_ht = int'(c_ht[g]);
          p_vv = int'(c_vv[g]); p_vf = int'(c_vf[g]); p_vs = int'(c_vs[g]); p_vt = int'(c_vt[g]);
          m_pend = 1'b1;
        end
        q.push_back(predict(1'b0));
      end
    end

    // The state left by reset is what the DUT shows until the first clock edge after release.
    always @(negedge rst) q.push_back(predict(1'b1));

    // Monitor: compare the DUT outputs with the next expected snapshot, once per clock.
    always @(negedge clk) begin
      obs_t got, exp;
      got = {o_col[g], o_row[g], o_vis[g], o_hs[g], o_vs[g], o_pend[g], o_np[g], o_nl[g], o_nf[g]};
      if (!rst && q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL lane%0d scoreboard t=%0t: got no expected entry, required one", g, $time);
      end else begin
        exp = rst ? predict(1'b1) : q.pop_front();
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL lane%0d outputs t=%0t got col=%0d row=%0d vis=%b hs=%b vs=%b pend=%b np=%b nl=%b nf=%b required col=%0d row=%0d vis=%b hs=%b vs=%b pend=%b np=%b nl=%b nf=%b",
                   g, $time, got.col, got.row, got.visible, got.hsync, got.vsync, got.cfg_pend,
                   got.new_pxl, got.new_line, got.new_frame, exp.col, exp.row, exp.visible,
                   exp.hsync, exp.vsync, exp.cfg_pend, exp.new_pxl, exp.new_line, exp.new_frame);
        end
      end
      if (bad >= 40) finish_run();
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_cfg(int d, int hv, int hf, int hs, int ht, int vv, int vf, int vs, int vt);
    cfg_wr[d] = 1'b1;
    c_hv[d] = 11'(hv); c_hf[d] = 11'(hf); c_hs[d] = 11'(hs); c_ht[d] = 11'(ht);
    c_vv[d] = 10'(vv); c_vf[d] = 10'(vf); c_vs[d] = 10'(vs); c_vt[d] = 10'(vt);
    step(1);
    cfg_wr[d] = 1'b0;
  endtask

  // Leaves the bench on a cycle with new_frame high; a write issued now lands on the apply edge.
  task automatic wait_frame(int d, int limit);
    int n = 0;
    while (!o_nf[d] && n < limit) begin
      step(1);
      n++;
    end
    total++;
    if (!o_nf[d]) begin
      bad++;
      $display("FAIL lane%0d frame_wait: new_frame still 0 after %0d clk, required 1", d, limit);
    end
  endtask

  task automatic random_write(int d);
    write_cfg(d, $urandom_range(0, 70), $urandom_range(0, 10), $urandom_range(0, 10),
              $urandom_range(0, 60), $urandom_range(0, 16), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 14));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      cfg_wr[d] = 1'b0;
      c_hv[d] = '0; c_hf[d] = '0; c_hs[d] = '0; c_ht[d] = '0;
      c_vv[d] = '0; c_vf[d] = '0; c_vs[d] = '0; c_vt[d] = '0;
    end
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step(500);

    // Mid-frame write. Lane 1 switches at its next frame. Lane 0 keeps running the
    // default timing with the write pending, because its frame is far longer than this run.
    write_cfg(1, 320, 8, 48, 400, 6, 1, 1, 8);
    write_cfg(0, 320, 8, 48, 400, 240, 4, 2, 262);
    wait_frame(1, 2000);
    step(3300);

    // A write on the new_frame cycle. The older pending set is applied and the new one stays pending.
    write_cfg(1, 30, 2, 4, 40, 5, 1, 1, 7);
    wait_frame(1, 4000);
    write_cfg(1, 24, 0, 3, 32, 4, 0, 2, 6);
    wait_frame(1, 400);
    step(1);
    wait_frame(1, 400);
    step(300);

    // Zero sync width, zero porch, visible beyond total, and zero totals.
    write_cfg(1, 20, 3, 0, 30, 4, 1, 1, 6);
    wait_frame(1, 500);
    step(400);
    write_cfg(1, 50, 2, 2, 10, 3, 1, 1, 0);
    wait_frame(1, 500);
    step(100);
    write_cfg(1, 5, 1, 1, 0, 2, 0, 1, 4);
    wait_frame(1, 100);
    step(50);

    // Reset mid-frame while both lanes hold a pending config.
    write_cfg(1, 10, 2, 3, 20, 3, 1, 1, 5);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(600);

    // Random writes, back-to-back overwrites and reset pulses.
    for (int i = 0; i < 24; i++) begin
      random_write($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) random_write(1);
      if ($urandom_range(0, 5) == 0) begin
        rst = 1'b1;
        step($urandom_range(1, 3));
        rst = 1'b0;
      end
      step($urandom_range(1, 1500));
    end

    finish_run();
  end

endmodule
